// File: rtl/vram_pixel_receiver_if.sv
// Pixel-write pin bus from the GPU transmitter plus the SRAM write handshake.
// The slave modport is the receiver; master is the transmitter/SRAM side.
interface vram_pixel_receiver_if #(
    parameter int ADDR_W  = 18,
    parameter int COLOR_W = 16
);
    logic               vram_write_pixel;
    logic [ADDR_W-1:0]  vram_raster_address;
    logic [COLOR_W-1:0] vram_raster_color;
    logic               vram_offset;

    logic               sram_req;
    logic [ADDR_W:0]    sram_addr;
    logic [COLOR_W-1:0] sram_wdata;
    logic               sram_ack;

    modport master (
        output vram_write_pixel, vram_raster_address, vram_raster_color, vram_offset,
        output sram_ack,
        input  sram_req, sram_addr, sram_wdata
    );

    modport slave (
        input  vram_write_pixel, vram_raster_address, vram_raster_color, vram_offset,
        input  sram_ack,
        output sram_req, sram_addr, sram_wdata
    );
endinterface

// File: rtl/vram_pixel_receiver.sv
// Captures pixel writes off the VRAM pin bus, queues them and replays them to SRAM,
// flipping the display buffer only once every write to the finished buffer has landed.
module vram_pixel_receiver #(
    parameter int ADDR_W     = 18,
    parameter int COLOR_W    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  vram_rst_i,
    vram_pixel_receiver_if.slave  bus,
    output logic                  disp_buffer,
    output logic                  frame_done,
    output logic                  overflow,
    output logic [31:0]           pixels_written
);
    localparam int ENTRY_W = 1 + ADDR_W + COLOR_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, REQ} state_t;

    state_t state, state_next;

    logic                rst;
    logic                c_strobe;
    logic [ADDR_W-1:0]   c_addr;
    logic [COLOR_W-1:0]  c_color;
    logic                c_offset;

    logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      count, count_next;
    logic                full, empty, push, pop;
    logic [ENTRY_W-1:0]  head;

    logic                draw_buf;
    logic                swap_pending;
    logic                commit;

    assign rst   = wb_rst_i | vram_rst_i;
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    // Full is judged before any same-cycle pop, so a pop never makes room for the push.
    assign push  = c_strobe & ~full;
    assign pop   = (state == REQ) & bus.sram_ack;
    assign head  = mem[rd_ptr];
    assign commit = swap_pending & (c_offset != draw_buf) & empty & (state == IDLE);

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            c_strobe <= 1'b0;
            c_addr   <= '0;
            c_color  <= '0;
            c_offset <= 1'b0;
        end else begin
            c_strobe <= bus.vram_write_pixel;
            c_addr   <= bus.vram_raster_address;
            c_color  <= bus.vram_raster_color;
            c_offset <= bus.vram_offset;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= {c_offset, c_addr, c_color};
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + (PTR_W + 1)'(1);
            2'b01:   count_next = count - (PTR_W + 1)'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next     = state;
        bus.sram_req   = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        case (state)
            IDLE: begin
                if (!empty) state_next = REQ;
            end
            REQ: begin
                bus.sram_req   = 1'b1;
                bus.sram_addr  = head[ENTRY_W-1 -: ADDR_W+1];
                bus.sram_wdata = head[COLOR_W-1:0];
                if (bus.sram_ack && (count_next == '0)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            pixels_written <= '0;
            overflow       <= 1'b0;
            disp_buffer    <= 1'b1;
            draw_buf       <= 1'b0;
            swap_pending   <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr         <= rd_ptr + PTR_W'(1);
                pixels_written <= pixels_written + 32'd1;
            end
            if (c_strobe && full) overflow <= 1'b1;
            frame_done <= commit;
            // Pending tracks the live offset, so a toggle back before commit cancels the flip.
            if (commit) begin
                disp_buffer  <= draw_buf;
                draw_buf     <= c_offset;
                swap_pending <= 1'b0;
            end else begin
                swap_pending <= (c_offset != draw_buf);
            end
        end
    end
endmodule
